// File: rtl/dec_fun_pkg.sv
// Shared types and default sizes for the programmable decoder / function generator.
package dec_fun_pkg;

  localparam int SEL_W_DEF   = 3;
  localparam int NUM_F_DEF   = 3;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dec_onehot.sv
// Combinational binary-to-one-hot decoder.
module dec_onehot #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/dec_fun_gen.sv
// Decoder with run-time programmable sum-of-minterm outputs and a self-timed sweep of all codes.
//
// state | meaning
// IDLE  | waiting; start launches a sweep, sel_vld loads cur_sel
// RUN   | sweeping codes 0..all-ones, each held dwell_q+1 cycles
// DONE  | one-cycle done pulse; accepts start/sel_vld like IDLE
module dec_fun_gen
  import dec_fun_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int NUM_F   = NUM_F_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [SEL_W-1:0]                         sel_in,
  input  logic                                     sel_vld,
  input  logic                                     start,
  input  logic [DWELL_W-1:0]                       dwell,
  input  logic                                     tt_we,
  input  logic [((NUM_F > 1) ? $clog2(NUM_F) : 1)-1:0] tt_idx,
  input  logic [2**SEL_W-1:0]                      tt_data,
  output logic [SEL_W-1:0]                         cur_sel,
  output logic [2**SEL_W-1:0]                      dec_out,
  output logic [NUM_F-1:0]                         f,
  output logic                                     f_vld,
  output logic                                     busy,
  output logic                                     done
);

  localparam int CODES = 2**SEL_W;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               f_vld_q, f_vld_d;
  logic [CODES-1:0]   tt_q [NUM_F];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      f_vld_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      f_vld_q   <= f_vld_d;
    end
  end

  // Out-of-range indices match no k and are silently dropped.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_F; k++) begin
      if (rst)
        tt_q[k] <= '0;
      else if (tt_we && (int'(tt_idx) == k))
        tt_q[k] <= tt_data;
    end
  end

  // cnt is a down-counter reloaded from dwell_q; zero is the terminal count for a code.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    f_vld_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d   = RUN;
          cur_sel_d = '0;
          dwell_d   = dwell;
          cnt_d     = dwell;
          f_vld_d   = 1'b1;
        end else if (sel_vld) begin
          cur_sel_d = sel_in;
          f_vld_d   = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (cur_sel_q == '1) begin
          state_d = DONE;
        end else begin
          cur_sel_d = cur_sel_q + 1'b1;
          cnt_d     = dwell_q;
          f_vld_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dec_onehot #(.SEL_W(SEL_W)) u_dec (
    .sel    (cur_sel_q),
    .onehot (dec_out)
  );

  always_comb begin
    for (int k = 0; k < NUM_F; k++)
      f[k] = |(dec_out & tt_q[k]);
  end

  assign cur_sel = cur_sel_q;
  assign f_vld   = f_vld_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_dec_fun_gen.sv
// Directed bench for dec_fun_gen: a scoreboard of expected codes checked on every f_vld pulse.
module tb_dec_fun_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sel_in = '0;
  logic       sel_vld = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dwell = '0;
  logic       tt_we = 1'b0;
  logic [1:0] tt_idx = '0;
  logic [7:0] tt_data = '0;
  logic [2:0] cur_sel;
  logic [7:0] dec_out;
  logic [2:0] f;
  logic       f_vld, busy, done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_vld = 0;

  typedef struct {
    logic [2:0] sel;
    int         gap;
  } exp_t;
  exp_t sb[$];

  logic [7:0] model_tt [3];
  logic [2:0] exp3 [8];

  dec_fun_gen dut (
    .clk(clk), .rst(rst), .sel_in(sel_in), .sel_vld(sel_vld), .start(start),
    .dwell(dwell), .tt_we(tt_we), .tt_idx(tt_idx), .tt_data(tt_data),
    .cur_sel(cur_sel), .dec_out(dec_out), .f(f), .f_vld(f_vld),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_f(input logic [2:0] code);
    logic [2:0] r;
    for (int k = 0; k < 3; k++) r[k] = model_tt[k][code];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_sweep(input int dw);
    for (int c = 0; c < 8; c++) sb.push_back('{sel: 3'(c), gap: (c == 0) ? 0 : dw + 1});
  endtask

  task automatic model_write(input logic [1:0] idx, input logic [7:0] data);
    tt_we = 1'b1; tt_idx = idx; tt_data = data;
    if (idx < 2'd3) model_tt[idx] = data;
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (!rst && f_vld) begin
      if (sb.size() == 0) begin
        chk("fvld_unexpected", 32'(f_vld), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_sel", 32'(cur_sel), 32'(e.sel));
        chk("sb_dec", 32'(dec_out), 32'(8'd1 << e.sel));
        chk("sb_f", 32'(f), 32'(model_f(e.sel)));
        if (e.gap != 0) chk("sb_gap", 32'(cyc - last_vld), 32'(e.gap));
      end
      last_vld = cyc;
    end
  end

  initial begin
    int done_cyc;
    int done_cnt;
    for (int k = 0; k < 3; k++) model_tt[k] = '0;
    exp3 = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b001, 3'b010, 3'b010, 3'b011};

    // Power-on reset state
    tick(); tick();
    chk("rst_cur_sel", 32'(cur_sel), 32'd0);
    chk("rst_dec_out", 32'(dec_out), 32'h01);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_busy_fvld_done", {29'd0, busy, f_vld, done}, 32'd0);
    rst = 1'b0;

    // Load tables, then reset mid-sweep
    model_write(2'd0, 8'h96); tick();
    model_write(2'd1, 8'hE8); tick();
    tt_we = 1'b0;
    start = 1'b1; dwell = 8'd0; push_sweep(0); tick();
    start = 1'b0; tick(); tick();
    rst = 1'b1; sb.delete();
    for (int k = 0; k < 3; k++) model_tt[k] = '0;
    tick(); tick();
    chk("midrst_cur_sel", 32'(cur_sel), 32'd0);
    chk("midrst_dec_out", 32'(dec_out), 32'h01);
    chk("midrst_f", 32'(f), 32'd0);
    chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);

    // Table load with concurrent select capture
    model_write(2'd0, 8'h96); tick();
    model_write(2'd2, 8'h01); tick();
    model_write(2'd1, 8'hE8);
    sel_vld = 1'b1; sel_in = 3'd7; sb.push_back('{sel: 3'd7, gap: 0});
    tick();
    tt_we = 1'b0; sel_vld = 1'b0;
    chk("sel7_cur_sel", 32'(cur_sel), 32'd7);
    chk("sel7_dec_out", 32'(dec_out), 32'h80);
    chk("sel7_f", 32'(f), 32'b011);
    chk("sel7_fvld", 32'(f_vld), 32'd1);
    tick();
    chk("sel7_fvld_pulse", 32'(f_vld), 32'd0);

    // Sweep dwell=0
    start = 1'b1; dwell = 8'd0; push_sweep(0);
    done_cyc = -1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      start = 1'b0;
      if (c <= 8) chk("sw0_f_seq", 32'(f), 32'(exp3[c-1]));
      if (c == 1) chk("sw0_busy", 32'(busy), 32'd1);
      if (done && done_cyc < 0) begin
        done_cyc = c;
        chk("sw0_busy_at_done", 32'(busy), 32'd0);
        chk("sw0_sel_at_done", 32'(cur_sel), 32'd7);
      end
      if (c == done_cyc + 1 && done_cyc > 0) chk("sw0_done_pulse", 32'(done), 32'd0);
    end
    chk("sw0_done_cycle", 32'(done_cyc), 32'd9);

    // Sweep dwell=3 with ignored requests and mid-sweep table writes
    start = 1'b1; dwell = 8'd3; push_sweep(3);
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0; sel_vld = 1'b0; tt_we = 1'b0; dwell = 8'd0;
      if (c == 6) begin start = 1'b1; sel_vld = 1'b1; sel_in = 3'd2; end
      if (c == 7) chk("sw3_ignore_sel", 32'(cur_sel), 32'd1);
      if (c == 21) model_write(2'd1, 8'h00);
      if (c == 22) begin
        chk("sw3_tt1_clear_f1", 32'(f[1]), 32'd0);
        chk("sw3_tt1_sel", 32'(cur_sel), 32'd5);
        chk("sw3_tt1_no_fvld", 32'(f_vld), 32'd0);
        model_write(2'd3, 8'hFF);
      end
      if (c == 23) chk("sw3_idx3_ignored", 32'(f), 32'(model_f(3'd5)));
      if (done && done_cyc < 0) done_cyc = c;
    end
    chk("sw3_done_cycle", 32'(done_cyc), 32'd33);

    // start and sel_vld together: sweep wins; restart from DONE
    start = 1'b1; sel_vld = 1'b1; sel_in = 3'd5; dwell = 8'd0; push_sweep(0);
    tick();
    start = 1'b0; sel_vld = 1'b0;
    chk("prio_cur_sel", 32'(cur_sel), 32'd0);
    done_cyc = -1;
    for (int c = 2; c <= 12 && done_cyc < 0; c++) begin
      tick();
      if (done) done_cyc = c;
    end
    chk("restart_done_seen", 32'(done_cyc), 32'd9);
    start = 1'b1; dwell = 8'd1; push_sweep(1);
    tick();
    start = 1'b0;
    chk("restart_sel", 32'(cur_sel), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    done_cyc = -1;
    for (int c = 2; c <= 25 && done_cyc < 0; c++) begin
      tick();
      if (done) done_cyc = c;
    end
    chk("restart_done_cycle", 32'(done_cyc), 32'd17);

    tick(); tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
